// File: rtl/csr_irq_pkg.sv
// csr_irq_pkg: shared offsets, field positions and masked-write helper for the timer/irq unit
package csr_irq_pkg;
  localparam logic [1:0] OFF_TCFG = 2'd0;
  localparam logic [1:0] OFF_TVAL = 2'd1;
  localparam logic [1:0] OFF_TICLR = 2'd2;
  localparam int OFF_IRQ_MODE = 0;
  localparam int OFF_IRQ_PEND = 1;
  localparam int TCFG_EN = 0;
  localparam int TCFG_PERIOD = 1;
  localparam int TCFG_INITV_LSB = 2;
  localparam int TICLR_CLR = 0;
  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] wmask, input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old);
  endfunction
endpackage

// File: rtl/csr_timer_chan.sv
// csr_timer_chan: one one-shot/periodic down-counter with sticky pending and its TCFG/TVAL/TICLR registers
module csr_timer_chan
  import csr_irq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  off,
  input  logic        we,
  input  logic [31:0] wmask,
  input  logic [31:0] wvalue,
  output logic [31:0] rdata,
  output logic        pend
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:2] initval;
  logic en, periodic, cfg_we, clr, zero;
  logic [31:0] cfg, cfg_new;
  always_comb begin
    cfg = 32'({initval, periodic, en});
    cfg_new = wmerge(cfg, wmask, wvalue);
    cfg_we = sel && we && off == OFF_TCFG;
    clr = sel && we && off == OFF_TICLR && wmask[TICLR_CLR] && wvalue[TICLR_CLR];
    zero = en && cnt == '0;
    rdata = !sel ? '0 : off == OFF_TCFG ? cfg : off == OFF_TVAL ? 32'(cnt) : '0;
  end
  // counting uses the pre-write en, so a disabling write still lets that edge count
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '1;
      en <= 1'b0;
      periodic <= 1'b0;
      initval <= '0;
      pend <= 1'b0;
    end else begin
      pend <= zero | (pend & ~clr);
      if (cfg_we) begin
        en <= cfg_new[TCFG_EN];
        periodic <= cfg_new[TCFG_PERIOD];
        initval <= cfg_new[CNT_W-1:TCFG_INITV_LSB];
      end
      if (cfg_we && cfg_new[TCFG_EN]) cnt <= {cfg_new[CNT_W-1:TCFG_INITV_LSB], 2'b00};
      else if (en && cnt != '1) cnt <= (zero && periodic) ? {initval, 2'b00} : cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/csr_timer_irq_unit.sv
// csr_timer_irq_unit: timer bank plus synchronised level/edge hw interrupt front end on the CSR port
module csr_timer_irq_unit
  import csr_irq_pkg::*;
#(
  parameter int          NUM_TMR     = 4,
  parameter int          CNT_W       = 32,
  parameter int          NUM_HWI     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [13:0] TMR_BASE    = 14'h60,
  parameter logic [13:0] IRQ_BASE    = 14'h70
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [13:0]        csr_num,
  input  logic               csr_we,
  input  logic [31:0]        csr_wmask,
  input  logic [31:0]        csr_wvalue,
  output logic [31:0]        csr_rvalue,
  output logic               csr_hit,
  input  logic [NUM_HWI-1:0] hw_int_in,
  output logic [NUM_HWI-1:0] hwi_pend,
  output logic [NUM_TMR-1:0] ti_pend,
  output logic               ti_any
);
  logic [13:0] toff;
  logic tmr_hit, mode_hit, pend_hit, mode_we;
  logic [31:0] rd [NUM_TMR];
  logic [SYNC_STAGES-1:0][NUM_HWI-1:0] sync;
  logic [NUM_HWI-1:0] s, s_d, sticky, mode, mode_new, pend_clr, mode_chg;
  assign toff = csr_num - TMR_BASE;
  assign tmr_hit = toff < 14'(4 * NUM_TMR) && toff[1:0] != 2'd3;
  for (genvar i = 0; i < NUM_TMR; i++) begin : g_chan
    csr_timer_chan #(.CNT_W(CNT_W)) u_chan (
      .clk(clk), .reset(reset), .sel(tmr_hit && toff[13:2] == 12'(i)), .off(toff[1:0]),
      .we(csr_we), .wmask(csr_wmask), .wvalue(csr_wvalue), .rdata(rd[i]), .pend(ti_pend[i])
    );
  end
  always_comb begin
    mode_hit = csr_num == IRQ_BASE + 14'(OFF_IRQ_MODE);
    pend_hit = csr_num == IRQ_BASE + 14'(OFF_IRQ_PEND);
    mode_we = mode_hit && csr_we;
    mode_new = NUM_HWI'(wmerge(32'(mode), csr_wmask, csr_wvalue));
    mode_chg = mode_we ? mode_new ^ mode : '0;
    pend_clr = (pend_hit && csr_we) ? csr_wmask[NUM_HWI-1:0] & csr_wvalue[NUM_HWI-1:0] : '0;
    s = sync[SYNC_STAGES-1];
    hwi_pend = (mode & sticky) | (~mode & s);
    ti_any = |ti_pend;
    csr_hit = tmr_hit | mode_hit | pend_hit;
    csr_rvalue = (mode_hit ? 32'(mode) : '0) | (pend_hit ? 32'(hwi_pend) : '0);
    for (int i = 0; i < NUM_TMR; i++) csr_rvalue = csr_rvalue | rd[i];
  end
  // edges only latch while a line is in edge mode; a mode change drops any stale sticky bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      s_d <= '0;
      sticky <= '0;
      mode <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], hw_int_in};
      s_d <= s;
      sticky <= (s & ~s_d & mode) | (sticky & ~(pend_clr | mode_chg));
      if (mode_we) mode <= mode_new;
    end
  end
endmodule
